// File: rtl/sec_to_mmss.sv
// Converts an elapsed-seconds count into four BCD digits (MM:SS) using a serial
// restoring divide-by-60 followed by parallel double dabble. Define MMSS_CLAMP_EN to clamp >=3600 s to 59:59.
module sec_to_mmss #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] sec_count,
    output logic             busy,
    output logic             done,
    output logic [3:0]       min_tens,
    output logic [3:0]       min_ones,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        BCD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [CNT_W-1:0] quo_q;
    logic [5:0]       rem_q;
    logic [14:0]      mdd_q;
    logic [14:0]      sdd_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       min_tens_q;
    logic [3:0]       min_ones_q;
    logic [3:0]       sec_tens_q;
    logic [3:0]       sec_ones_q;

    // Dividend bits leave quo_q at the top while quotient bits enter at the bottom.
    logic [6:0]       rsh_d;
    logic             ge_d;
    logic [5:0]       rem_d;
    logic [CNT_W-1:0] quo_d;

    always_comb begin
        rsh_d = {rem_q, quo_q[CNT_W-1]};
        ge_d  = (rsh_d >= 7'd60);
        rem_d = ge_d ? 6'(rsh_d - 7'd60) : rsh_d[5:0];
        quo_d = {quo_q[CNT_W-2:0], ge_d};
    end

    // One double-dabble step: {tens, ones, binary[6:0]}; adjust nibbles, then shift.
    function automatic logic [14:0] dabble(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

`ifdef MMSS_CLAMP_EN
    logic ovf_q;
    logic overflow_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
`ifdef MMSS_CLAMP_EN
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            busy_q <= (state_q == DIV) || (state_q == BCD);
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        quo_q   <= sec_count;
                        rem_q   <= '0;
                        cnt_q   <= 4'(CNT_W - 1);
`ifdef MMSS_CLAMP_EN
                        ovf_q   <= (32'(sec_count) >= 32'd3600);
`endif
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    if (cnt_q == 4'd0) begin
                        mdd_q   <= {8'b0, 7'(quo_d)};
                        sdd_q   <= {9'b0, rem_d};
                        cnt_q   <= 4'd6;
                        state_q <= BCD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                BCD: begin
                    mdd_q <= dabble(mdd_q);
                    sdd_q <= dabble(sdd_q);
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
`ifdef MMSS_CLAMP_EN
                    overflow_q <= ovf_q;
                    if (ovf_q) begin
                        min_tens_q <= 4'd5;
                        min_ones_q <= 4'd9;
                        sec_tens_q <= 4'd5;
                        sec_ones_q <= 4'd9;
                    end else begin
                        min_tens_q <= mdd_q[14:11];
                        min_ones_q <= mdd_q[10:7];
                        sec_tens_q <= sdd_q[14:11];
                        sec_ones_q <= sdd_q[10:7];
                    end
`else
                    min_tens_q <= mdd_q[14:11];
                    min_ones_q <= mdd_q[10:7];
                    sec_tens_q <= sdd_q[14:11];
                    sec_ones_q <= sdd_q[10:7];
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
`ifdef MMSS_CLAMP_EN
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sec_to_mmss.sv
// Directed plus randomized bench for sec_to_mmss with an arithmetic MM:SS reference model.
module tb_sec_to_mmss;

    localparam int CNT_W = 12;
    localparam int LAT   = CNT_W + 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] sec_count;
    logic             busy;
    logic             done;
    logic [3:0]       min_tens, min_ones, sec_tens, sec_ones;
    logic             overflow;

    int tests = 0;
    int fails = 0;

    sec_to_mmss #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sec_count (sec_count),
        .busy      (busy),
        .done      (done),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input int v);
        int m, s;
`ifdef MMSS_CLAMP_EN
        if (v >= 3600) return {1'b1, 16'h5959};
`endif
        m = v / 60;
        s = v % 60;
        return {1'b0, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [16:0] observed();
        return {overflow, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion, scramble sec_count after capture, check timing and digits.
    task automatic convert(input int v, input string tag);
        int lat, bcnt;
        logic [16:0] res;
        sec_count = CNT_W'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        sec_count = CNT_W'($urandom);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        res = observed();
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_busycnt"}, bcnt, CNT_W + 7);
        chk({tag, "_busy_in_done"}, {31'b0, busy}, 0);
        chk({tag, "_digits"}, {15'b0, res}, {15'b0, model(v)});
        step();
        chk({tag, "_done_1cyc"}, {31'b0, done}, 0);
        chk({tag, "_hold"}, {15'b0, observed()}, {15'b0, model(v)});
    endtask

    initial begin
        int pulses, last, n;
        int stamps[$];
        logic [16:0] res;

        rst = 1'b1;
        start = 1'b0;
        sec_count = '0;
        step();
        step();
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_digits", {15'b0, observed()}, 0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        sec_count = CNT_W'(125);
        step();
        rst = 1'b0;
        start = 1'b0;
        step();
        step();
        chk("rst_prio_busy", {31'b0, busy}, 0);

        convert(0, "zero");
        convert(125, "v125");
        convert(3599, "v3599");
        convert(4095, "v4095");

        // A second start during the conversion must be ignored.
        sec_count = CNT_W'(60);
        start = 1'b1;
        step();
        start = 1'b0;
        sec_count = CNT_W'(61);
        pulses = 0;
        res = '0;
        for (int i = 1; i <= 45; i++) begin
            start = (i == 5);
            step();
            if (done) begin
                pulses++;
                res = observed();
            end
        end
        start = 1'b0;
        chk("ignore_start_pulses", pulses, 1);
        chk("ignore_start_digits", {15'b0, res}, {15'b0, model(60)});

        // Abort mid-conversion with reset.
        sec_count = CNT_W'(754);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy_now", {31'b0, busy}, 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_digits", {15'b0, observed()}, 0);
        convert(754, "v754");

        // Start held high gives back-to-back conversions.
        sec_count = CNT_W'(59);
        start = 1'b1;
        n = 0;
        while (stamps.size() < 3 && n < 80) begin
            step();
            n++;
            if (done) begin
                stamps.push_back(n);
                chk("b2b_digits", {15'b0, observed()}, {15'b0, model(59)});
            end
        end
        start = 1'b0;
        chk("b2b_pulses", stamps.size(), 3);
        chk("b2b_first", stamps.size() > 0 ? stamps[0] : -1, LAT + 1);
        last = -1;
        for (int i = 1; i < stamps.size(); i++) begin
            chk("b2b_spacing", stamps[i] - stamps[i-1], LAT + 1);
        end
        for (int i = 0; i < 25; i++) step();
        chk("b2b_idle_busy", {31'b0, busy}, 0);

        for (int i = 0; i < 10; i++) begin
            convert(int'($urandom_range(0, (1 << CNT_W) - 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sec_to_mmss.md
SEC_TO_MMSS -- requirements
Module: sec_to_mmss

Interface
REQ-001 Parameter CNT_W, default 12, is the elapsed-seconds input width; legal range 6..12.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 start  input  1  conversion request, sampled at the rising edge of clk.
REQ-005 sec_count  input  CNT_W  elapsed seconds from the parking-time counter, unsigned.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when new digits become valid.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits of MM:SS for the display driver.
REQ-009 overflow  output  1  displayed value was clamped (see Configuration).

Function
REQ-010 FSM states SHALL be IDLE, DIV, BCD and DONE, with a registered state encoding.
REQ-011 In IDLE, start=1 at edge k SHALL capture sec_count into a working register and enter DIV.
REQ-012 DIV SHALL run restoring division by 60, one quotient bit per cycle, for CNT_W cycles, giving minutes (quotient) and seconds (remainder, 0..59).
REQ-013 BCD SHALL run shift-add-3 (double dabble) on minutes and seconds in parallel, 7 cycles, with add-3 applied to a nibble when it is >=5 before each shift.
REQ-014 DONE SHALL last exactly 1 cycle and then return to IDLE.
REQ-015 The four digit outputs and overflow SHALL update only at the edge leaving DONE, edge k+CNT_W+8, and SHALL otherwise hold their values.
REQ-016 done SHALL be high only in the cycle after edge k+CNT_W+8.
REQ-017 busy SHALL be high after edges k+1 through k+CNT_W+7, and low in IDLE and in the done cycle.
REQ-018 start SHALL be ignored while busy or in DONE; there is no queueing.
REQ-019 start held high SHALL begin a new conversion in the done cycle if still asserted, giving back-to-back operation.
REQ-020 A change on sec_count after capture SHALL NOT affect the conversion in flight.
REQ-021 All arithmetic SHALL be unsigned, with no truncation of the quotient for any legal CNT_W.

Reset
REQ-022 rst=1 at any edge SHALL force IDLE, with busy=0, done=0, all digits 0 and overflow=0.
REQ-023 rst SHALL take priority over start at the same edge.
REQ-024 rst during DIV or BCD SHALL abort the conversion; the digits read 00:00 and no done pulse follows.

Configuration
REQ-025 The macro MMSS_CLAMP_EN SHALL control clamping of long parking times.
REQ-026 With MMSS_CLAMP_EN defined, a captured value >=3600 SHALL produce 59:59 with overflow=1; values <3600 give overflow=0. Latency is unchanged.
REQ-027 Without MMSS_CLAMP_EN, minutes up to 68 SHALL display unclamped and overflow SHALL be tied to 0.

Verification
REQ-028 CNT_W=12: rst for 2 cycles, then start with sec_count=0 -> done at k+21, digits 0,0,0,0, busy high for exactly 19 cycles.
REQ-029 sec_count=125, start -> 0,2,0,5; sec_count=3599 -> 5,9,5,9 with overflow=0.
REQ-030 sec_count=4095 -> 5,9,5,9 with overflow=1 when MMSS_CLAMP_EN is defined; 6,8,1,5 with overflow=0 otherwise.
REQ-031 start=1 with sec_count=60, then sec_count changed to 61 and start pulsed at k+5 -> single done, result 0,1,0,0.
REQ-032 Start with sec_count=754, assert rst at k+10 -> no done, digits 0,0,0,0, busy=0; a subsequent start with 754 -> 1,2,3,4.
REQ-033 start held high with sec_count=59 -> done pulses every 21 cycles, digits 0,0,5,9 each time.
